// File: rtl/mw_pkg.sv
// mw_pkg: shared definitions for the microwave controller time-keeping blocks.
//   state_t    - countdown controller state encoding (IDLE/RUN/PAUSED/DONE)
//   BCD_SS_MAX - largest legal seconds value (59, BCD)
//   BCD_ZERO   - 00 in BCD
//   bcd2_dec   - two-digit BCD decrement, returns {borrow_out, tens, units}
//   bcd2_valid - both nibbles of a two-digit BCD value are decimal digits
package mw_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_PAUSED = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam logic [7:0] BCD_SS_MAX = 8'h59;
  localparam logic [7:0] BCD_ZERO   = 8'h00;

  // 00 decrements to 99 with borrow_out set; callers use the borrow to
  // cascade into the next-higher digit pair.
  function automatic logic [8:0] bcd2_dec(input logic [7:0] v);
    logic [3:0] tens;
    logic [3:0] units;
    logic       borrow;
    tens   = v[7:4];
    units  = v[3:0];
    borrow = 1'b0;
    if (units != 4'd0) begin
      units = units - 4'd1;
    end else begin
      units = 4'd9;
      if (tens != 4'd0) begin
        tens = tens - 4'd1;
      end else begin
        tens   = 4'd9;
        borrow = 1'b1;
      end
    end
    return {borrow, tens, units};
  endfunction

  function automatic logic bcd2_valid(input logic [7:0] v);
    return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
  endfunction

endpackage

// File: rtl/mw_countdown_timer_if.sv
// mw_countdown_timer_if: command and status bundle between the keypad/load
// logic (master) and the countdown timer (slave).
//   commands (master -> slave): door_open, load, load_mm, load_ss,
//                               start, pause, clear
//   status   (slave -> master): mm_bcd, ss_bcd, running, done, load_err,
//                               state (debug view of the controller FSM)
// Handshake: every command is a single-cycle request sampled on the rising
// clock edge; there is no ready/backpressure, the timer always accepts or
// ignores a request in the cycle it is presented. door_open is a level.
interface mw_countdown_timer_if;
  import mw_pkg::*;

  logic       door_open;
  logic       load;
  logic [7:0] load_mm;
  logic [7:0] load_ss;
  logic       start;
  logic       pause;
  logic       clear;
  logic [7:0] mm_bcd;
  logic [7:0] ss_bcd;
  logic       running;
  logic       done;
  logic       load_err;
  state_t     state;

  modport master (
    output door_open, load, load_mm, load_ss, start, pause, clear,
    input  mm_bcd, ss_bcd, running, done, load_err, state
  );

  modport slave (
    input  door_open, load, load_mm, load_ss, start, pause, clear,
    output mm_bcd, ss_bcd, running, done, load_err, state
  );

endinterface

// File: rtl/mw_countdown_timer_tick_sync_edge.sv
// tick_sync_edge: brings the divider's slow square wave into the clk domain
// and turns each rising edge of it into a one-cycle pulse.
//   clk        - system clock
//   reset      - asynchronous active-high reset, clears all flops
//   async_in   - square wave, asynchronous to clk
//   rise_pulse - one clk cycle high per rising edge of async_in
module tick_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic rise_pulse
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  // Only the last synchronizer stage is compared against its delayed copy,
  // so each input edge yields exactly one pulse.
  assign rise_pulse = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/mw_countdown_timer.sv
// mw_countdown_timer: MM:SS BCD cooking-time countdown with start/pause/clear
// control and door interlock.
//   clk     - system clock
//   reset   - asynchronous active-high reset
//   tick_in - one-second square wave from the clock divider (asynchronous)
//   bus     - slave side of mw_countdown_timer_if (commands in, time/status
//             out, plus the FSM state for observation)
// Command priority within a cycle: clear > load > pause > start; a door open
// in RUN and the second tick are handled after the commands, so any command
// on the same edge suppresses the decrement.
module mw_countdown_timer
  import mw_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  tick_in,
  mw_countdown_timer_if.slave   bus
);

  state_t     state_q, state_d;
  logic [7:0] mm_q, mm_d;
  logic [7:0] ss_q, ss_d;
  logic       done_q, done_d;
  logic       err_q, err_d;

  logic       sec_tick;
  logic       load_ok;
  logic       time_zero;
  logic [8:0] ss_dec;
  logic [8:0] mm_dec;

  tick_sync_edge #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_tick_sync_edge (
    .clk        (clk),
    .reset      (reset),
    .async_in   (tick_in),
    .rise_pulse (sec_tick)
  );

  assign load_ok   = bcd2_valid(bus.load_mm) && bcd2_valid(bus.load_ss) &&
                     (bus.load_ss <= BCD_SS_MAX);
  assign time_zero = (mm_q == BCD_ZERO) && (ss_q == BCD_ZERO);
  assign ss_dec    = bcd2_dec(ss_q);
  assign mm_dec    = bcd2_dec(mm_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      mm_q    <= BCD_ZERO;
      ss_q    <= BCD_ZERO;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mm_q    <= mm_d;
      ss_q    <= ss_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    mm_d    = mm_q;
    ss_d    = ss_q;
    done_d  = 1'b0;
    err_d   = 1'b0;

    if (bus.clear) begin
      state_d = ST_IDLE;
      mm_d    = BCD_ZERO;
      ss_d    = BCD_ZERO;
    end else if (bus.load && (state_q != ST_RUN)) begin
      if (load_ok) begin
        mm_d    = bus.load_mm;
        ss_d    = bus.load_ss;
        state_d = ST_IDLE;
      end else begin
        err_d = 1'b1;
      end
    end else if (bus.pause && (state_q == ST_RUN)) begin
      state_d = ST_PAUSED;
    end else if (bus.start && ((state_q == ST_IDLE) || (state_q == ST_PAUSED)) &&
                 !bus.door_open && !time_zero) begin
      state_d = ST_RUN;
    end else if ((state_q == ST_RUN) && bus.door_open) begin
      state_d = ST_PAUSED;
    end else if ((state_q == ST_RUN) && sec_tick) begin
      // Seconds borrow cascades into minutes; the minutes borrow guard keeps
      // 00:00 from wrapping even though RUN never holds 00:00.
      if (!ss_dec[8]) begin
        ss_d = ss_dec[7:0];
        if ((mm_q == BCD_ZERO) && (ss_dec[7:0] == BCD_ZERO)) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end
      end else if (!mm_dec[8]) begin
        ss_d = BCD_SS_MAX;
        mm_d = mm_dec[7:0];
      end
    end
  end

  assign bus.mm_bcd   = mm_q;
  assign bus.ss_bcd   = ss_q;
  assign bus.running  = (state_q == ST_RUN);
  assign bus.done     = done_q;
  assign bus.load_err = err_q;
  assign bus.state    = state_q;

endmodule

// File: doc/mw_countdown_timer.md
# mw_countdown_timer

Cooking-time countdown for the microwave controller: consumes the slow square-wave output of the 100:1 clock divider as a seconds time base, holds an MM:SS BCD cooking time, and counts it down to 00:00 under start/pause/clear control with a door interlock. It sits between the keypad/load logic (upstream) and the display driver and magnetron/done-beeper control (downstream). It is the consumer end of the divider's `clk_out` interface.

## Interface
- `SYNC_STAGES`, 2: flip-flop stages synchronizing `tick_in`; legal range is 2 to 4.
- `clk` input 1: system clock; all state changes on its rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `tick_in` input 1: divided-clock square wave (one rising edge = one second); asynchronous to `clk`.
- `door_open` input 1: door interlock, level, already synchronous.
- `load` input 1: one-cycle request to load `load_mm`/`load_ss`.
- `load_mm` input 8: BCD minutes, {tens, units}.
- `load_ss` input 8: BCD seconds, {tens, units}.
- `start` input 1: one-cycle start/resume request.
- `pause` input 1: one-cycle pause request.
- `clear` input 1: one-cycle clear request.
- `mm_bcd` output 8: current minutes (BCD).
- `ss_bcd` output 8: current seconds (BCD).
- `running` output 1: high while in RUN.
- `done` output 1: one-cycle pulse when the count reaches 00:00 from RUN.
- `load_err` output 1: one-cycle pulse when a load is rejected.

## Operation
- Reset values: state IDLE, `mm_bcd`=8'h00, `ss_bcd`=8'h00, `running`=0, `done`=0, `load_err`=0, synchronizer and edge register cleared to 0.
- Time base: `tick_in` passes through SYNC_STAGES flops. `sec_tick` is the internal rising edge of the synchronized signal (sync & ~prev). Only one `sec_tick` occurs per `tick_in` rising edge.
- States: IDLE, RUN, PAUSED, DONE.
- Command priority in one cycle: clear > load > pause > start. Lower-priority requests in the same cycle are ignored.
- `clear`: accepted in any state. Sets time to 00:00 and state to IDLE. No `done` pulse.
- `load`: accepted in IDLE, PAUSED and DONE. It is ignored in RUN, with no error.
  - Valid load: every nibble ≤ 9 and `load_ss` ≤ 8'h59. Copies the inputs to the time; DONE and PAUSED go to IDLE.
  - Invalid load: time unchanged, `load_err` pulses.
- `start`: IDLE/PAUSED → RUN only when `door_open`=0 and time ≠ 00:00. Otherwise ignored.
- `pause`: RUN → PAUSED.
- Door interlock: `door_open`=1 in RUN forces PAUSED on that same edge. Closing the door does not resume; `start` is required.
- Countdown happens in RUN on `sec_tick` only:
  - `ss` units 1–9: decrement the units.
  - `ss` units 0, tens > 0: units become 9, tens decrement.
  - `ss`=00 and `mm` > 0: `ss` becomes 59, `mm` decrements with the same BCD borrow rule.
  - 00:01 → 00:00: state becomes DONE and `done` pulses on the same edge that 00:00 appears.
- `sec_tick` in IDLE, PAUSED or DONE has no effect. A pending tick edge is not remembered across pause.
- DONE holds 00:00 until `clear` or a valid `load`. `start` in DONE is ignored.

## Timing
- `tick_in` rising edge to count update: the time changes on the (SYNC_STAGES+1)-th `clk` edge after the first edge that samples `tick_in` high. With default 2, that is the 3rd edge.
- Commands take effect on the edge where they are sampled. Outputs are registered, with no combinational path from inputs to outputs.
- `tick_in` high and low phases must each last at least SYNC_STAGES+1 `clk` periods. Shorter pulses may be lost, and no behaviour is guaranteed for them.
- `sec_tick` coincident with `pause`, `clear`, `door_open`, or a transition into RUN: the command wins and no decrement occurs on that edge.
- Reset asserted mid-count: the block returns to reset values immediately and stays there until reset deasserts.

## Structure
- Shared package `mw_pkg`:
  - state encoding typedef (IDLE/RUN/PAUSED/DONE);
  - BCD constants `BCD_SS_MAX`=8'h59 and `BCD_ZERO`=8'h00;
  - function `bcd2_dec` (two-digit BCD decrement with borrow-out).
- One natural sub-module, `tick_sync_edge`: the SYNC_STAGES synchronizer plus rising-edge detector, with ports `clk`, `reset`, `async_in`, `rise_pulse`.

## Test plan
- Load 00:03, start, apply 4 `tick_in` edges → `ss` goes 02, 01, 00; `done` pulses exactly once, on the 00:00 edge; the 4th tick has no effect; state is DONE.
- Load 01:00, start, apply 1 tick → 00:59. Load 10:00 and tick → 09:59.
- Load 00:10, start, 2 ticks, pause, 3 ticks → holds 00:08. Start, 1 tick → 00:07.
- Load 00:05, start, raise `door_open` → PAUSED the same cycle. `start` while the door is open is ignored. Close the door, `start` → RUN.
- Load with `load_ss`=8'h60, then 8'h1A → `load_err` pulses each time and the time is unchanged. Load 00:00 and `start` → stays IDLE.
- `clear` and `start` in the same cycle during RUN at 00:30 → IDLE, 00:00. Assert `reset` mid-count → all outputs 0 asynchronously.
